instr_encoder: RTL and testbench

Streaming RV32I instruction encoder, the inverse of the core's control/decode path. It accepts one mnemonic-level operation per handshake: op, register indices and a 32-bit immediate. It emits the 32-bit machine word on a valid/ready output, and expands the LI pseudo-op into LUI+ADDI. It sits between the test-program sequencer and the instruction-memory loader, and every emitted word must decode as valid in the core's control unit.

---
 rtl/isa_enc_pkg.sv | 92 +++++++++
 rtl/rv32i_encode_comb.sv | 98 +++++++++
 rtl/instr_encoder.sv | 116 +++++++++++
 tb/tb_instr_encoder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_enc_pkg.sv
// rtl/isa_enc_pkg.sv - RV32I op enumeration, opcode/funct constants and format packers
package isa_enc_pkg;

  typedef enum logic [5:0] {
    OP_ADD   = 6'd0,  OP_SUB   = 6'd1,  OP_SLL   = 6'd2,  OP_SLT   = 6'd3,
    OP_SLTU  = 6'd4,  OP_XOR   = 6'd5,  OP_SRL   = 6'd6,  OP_SRA   = 6'd7,
    OP_OR    = 6'd8,  OP_AND   = 6'd9,
    OP_ADDI  = 6'd10, OP_SLTI  = 6'd11, OP_SLTIU = 6'd12, OP_XORI  = 6'd13,
    OP_ORI   = 6'd14, OP_ANDI  = 6'd15, OP_SLLI  = 6'd16, OP_SRLI  = 6'd17,
    OP_SRAI  = 6'd18,
    OP_LB    = 6'd19, OP_LH    = 6'd20, OP_LW    = 6'd21, OP_LBU   = 6'd22,
    OP_LHU   = 6'd23,
    OP_SB    = 6'd24, OP_SH    = 6'd25, OP_SW    = 6'd26,
    OP_BEQ   = 6'd27, OP_BNE   = 6'd28, OP_BLT   = 6'd29, OP_BGE   = 6'd30,
    OP_BLTU  = 6'd31, OP_BGEU  = 6'd32,
    OP_JAL   = 6'd33, OP_JALR  = 6'd34, OP_LUI   = 6'd35, OP_AUIPC = 6'd36,
    OP_LI    = 6'd37
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LI2  = 1'b1
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // All-zero word decodes as illegal in the core, so it doubles as the error word.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction

  // Branch offsets are always even, so bit 0 is never passed in.
  function automatic logic [31:0] enc_b(logic [12:1] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(logic [20:1] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

  function automatic logic [31:0] enc_u(logic [31:12] imm, logic [4:0] rd, logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

endpackage

// File: rtl/rv32i_encode_comb.sv
// rtl/rv32i_encode_comb.sv - combinational RV32I word encoder with range checks and LI split
module rv32i_encode_comb
  import isa_enc_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_err,
  output logic        o_is_li2,
  output logic [31:0] o_word2
);

  op_e         op;
  logic        fits12;
  logic        fits_sh;
  logic        fits_br;
  logic        fits_jal;
  logic        low12_zero;
  logic [19:0] li_hi;

  assign op = op_e'(i_op);

  // Range checks: a value fits N signed bits when all bits above N-1 equal the sign bit.
  always_comb begin
    fits12     = (i_imm[31:11] == '0) || (i_imm[31:11] == '1);
    fits_sh    = (i_imm[31:5] == '0);
    fits_br    = ((i_imm[31:12] == '0) || (i_imm[31:12] == '1)) && !i_imm[0];
    fits_jal   = ((i_imm[31:20] == '0) || (i_imm[31:20] == '1)) && !i_imm[0];
    low12_zero = (i_imm[11:0] == 12'h000);
    // Adding 0x800 before the shift carries into bit 12 exactly when imm[11] is set,
    // and the low part left over is just imm[11:0] reinterpreted as signed.
    li_hi      = i_imm[31:12] + {19'd0, i_imm[11]};
  end

  // Per-op format selection; any failed check forces the error word.
  always_comb begin
    o_word   = NOP_WORD;
    o_err    = 1'b0;
    o_is_li2 = 1'b0;
    o_word2  = NOP_WORD;
    case (op)
      OP_ADD:   o_word = enc_r(F7_BASE, i_rs2, i_rs1, F3_ADD_SUB, i_rd, OPC_OP);
      OP_SUB:   o_word = enc_r(F7_ALT,  i_rs2, i_rs1, F3_ADD_SUB, i_rd, OPC_OP);
      OP_SLL:   o_word = enc_r(F7_BASE, i_rs2, i_rs1, F3_SLL,     i_rd, OPC_OP);
      OP_SLT:   o_word = enc_r(F7_BASE, i_rs2, i_rs1, F3_SLT,     i_rd, OPC_OP);
      OP_SLTU:  o_word = enc_r(F7_BASE, i_rs2, i_rs1, F3_SLTU,    i_rd, OPC_OP);
      OP_XOR:   o_word = enc_r(F7_BASE, i_rs2, i_rs1, F3_XOR,     i_rd, OPC_OP);
      OP_SRL:   o_word = enc_r(F7_BASE, i_rs2, i_rs1, F3_SRL_SRA, i_rd, OPC_OP);
      OP_SRA:   o_word = enc_r(F7_ALT,  i_rs2, i_rs1, F3_SRL_SRA, i_rd, OPC_OP);
      OP_OR:    o_word = enc_r(F7_BASE, i_rs2, i_rs1, F3_OR,      i_rd, OPC_OP);
      OP_AND:   o_word = enc_r(F7_BASE, i_rs2, i_rs1, F3_AND,     i_rd, OPC_OP);
      OP_ADDI:  begin o_word = enc_i(i_imm[11:0], i_rs1, F3_ADD_SUB, i_rd, OPC_OP_IMM); o_err = !fits12; end
      OP_SLTI:  begin o_word = enc_i(i_imm[11:0], i_rs1, F3_SLT,     i_rd, OPC_OP_IMM); o_err = !fits12; end
      OP_SLTIU: begin o_word = enc_i(i_imm[11:0], i_rs1, F3_SLTU,    i_rd, OPC_OP_IMM); o_err = !fits12; end
      OP_XORI:  begin o_word = enc_i(i_imm[11:0], i_rs1, F3_XOR,     i_rd, OPC_OP_IMM); o_err = !fits12; end
      OP_ORI:   begin o_word = enc_i(i_imm[11:0], i_rs1, F3_OR,      i_rd, OPC_OP_IMM); o_err = !fits12; end
      OP_ANDI:  begin o_word = enc_i(i_imm[11:0], i_rs1, F3_AND,     i_rd, OPC_OP_IMM); o_err = !fits12; end
      OP_SLLI:  begin o_word = enc_r(F7_BASE, i_imm[4:0], i_rs1, F3_SLL,     i_rd, OPC_OP_IMM); o_err = !fits_sh; end
      OP_SRLI:  begin o_word = enc_r(F7_BASE, i_imm[4:0], i_rs1, F3_SRL_SRA, i_rd, OPC_OP_IMM); o_err = !fits_sh; end
      OP_SRAI:  begin o_word = enc_r(F7_ALT,  i_imm[4:0], i_rs1, F3_SRL_SRA, i_rd, OPC_OP_IMM); o_err = !fits_sh; end
      OP_LB:    begin o_word = enc_i(i_imm[11:0], i_rs1, F3_B,  i_rd, OPC_LOAD); o_err = !fits12; end
      OP_LH:    begin o_word = enc_i(i_imm[11:0], i_rs1, F3_H,  i_rd, OPC_LOAD); o_err = !fits12; end
      OP_LW:    begin o_word = enc_i(i_imm[11:0], i_rs1, F3_W,  i_rd, OPC_LOAD); o_err = !fits12; end
      OP_LBU:   begin o_word = enc_i(i_imm[11:0], i_rs1, F3_BU, i_rd, OPC_LOAD); o_err = !fits12; end
      OP_LHU:   begin o_word = enc_i(i_imm[11:0], i_rs1, F3_HU, i_rd, OPC_LOAD); o_err = !fits12; end
      OP_SB:    begin o_word = enc_s(i_imm[11:0], i_rs2, i_rs1, F3_B); o_err = !fits12; end
      OP_SH:    begin o_word = enc_s(i_imm[11:0], i_rs2, i_rs1, F3_H); o_err = !fits12; end
      OP_SW:    begin o_word = enc_s(i_imm[11:0], i_rs2, i_rs1, F3_W); o_err = !fits12; end
      OP_BEQ:   begin o_word = enc_b(i_imm[12:1], i_rs2, i_rs1, F3_BEQ);  o_err = !fits_br; end
      OP_BNE:   begin o_word = enc_b(i_imm[12:1], i_rs2, i_rs1, F3_BNE);  o_err = !fits_br; end
      OP_BLT:   begin o_word = enc_b(i_imm[12:1], i_rs2, i_rs1, F3_BLT);  o_err = !fits_br; end
      OP_BGE:   begin o_word = enc_b(i_imm[12:1], i_rs2, i_rs1, F3_BGE);  o_err = !fits_br; end
      OP_BLTU:  begin o_word = enc_b(i_imm[12:1], i_rs2, i_rs1, F3_BLTU); o_err = !fits_br; end
      OP_BGEU:  begin o_word = enc_b(i_imm[12:1], i_rs2, i_rs1, F3_BGEU); o_err = !fits_br; end
      OP_JAL:   begin o_word = enc_j(i_imm[20:1], i_rd); o_err = !fits_jal; end
      OP_JALR:  begin o_word = enc_i(i_imm[11:0], i_rs1, 3'b000, i_rd, OPC_JALR); o_err = !fits12; end
      OP_LUI:   begin o_word = enc_u(i_imm[31:12], i_rd, OPC_LUI);   o_err = !low12_zero; end
      OP_AUIPC: begin o_word = enc_u(i_imm[31:12], i_rd, OPC_AUIPC); o_err = !low12_zero; end
      OP_LI: begin
        if (fits12) begin
          o_word = enc_i(i_imm[11:0], 5'd0, F3_ADD_SUB, i_rd, OPC_OP_IMM);
        end else begin
          o_word   = enc_u(li_hi, i_rd, OPC_LUI);
          o_is_li2 = !low12_zero;
          o_word2  = enc_i(i_imm[11:0], i_rd, F3_ADD_SUB, i_rd, OPC_OP_IMM);
        end
      end
      default: o_err = 1'b1;
    endcase
    if (o_err) begin
      o_word = NOP_WORD;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streaming RV32I encoder: handshake, LI expansion FSM and output register
module instr_encoder
  import isa_enc_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [5:0]  i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_instr,
  output logic        o_err
);

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic [31:0] pend_q, pend_d;

  logic [31:0] enc_word;
  logic        enc_err;
  logic        enc_is_li2;
  logic [31:0] enc_word2;
  logic        accept;
  logic        consume;

  rv32i_encode_comb u_encode (
    .i_op     (i_op),
    .i_rd     (i_rd),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .i_imm    (i_imm),
    .o_word   (enc_word),
    .o_err    (enc_err),
    .o_is_li2 (enc_is_li2),
    .o_word2  (enc_word2)
  );

  assign accept  = i_in_valid && o_in_ready;
  assign consume = out_valid_q && i_out_ready;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: stay in S_LI2 until the LUI beat has been taken downstream.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && enc_is_li2) state_d = S_LI2;
      S_LI2:   if (consume) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: accept a new op only when idle and the output slot frees this cycle.
  always_comb begin
    o_in_ready = !i_rst && (state_q == S_IDLE) && (!out_valid_q || i_out_ready);
  end

  // Output register and pending-beat update.
  always_comb begin
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    err_d       = err_q;
    pend_d      = pend_q;
    if (state_q == S_LI2) begin
      if (consume) begin
        instr_d     = pend_q;
        err_d       = 1'b0;
        out_valid_d = 1'b1;
        pend_d      = NOP_WORD;
      end
    end else if (accept) begin
      instr_d     = enc_word;
      err_d       = enc_err;
      out_valid_d = 1'b1;
      if (enc_is_li2) begin
        pend_d = enc_word2;
      end
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  // Datapath registers; reset also drops any pending LI beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_valid_q <= 1'b0;
      instr_q     <= NOP_WORD;
      err_q       <= 1'b0;
      pend_q      <= NOP_WORD;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
    end
  end

  assign o_out_valid = out_valid_q;
  assign o_instr     = instr_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder with a beat-level reference model
module tb_instr_encoder;
  import isa_enc_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [5:0]  i_op;
  logic [4:0]  i_rd;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [31:0] i_imm;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_instr;
  logic        o_err;

  instr_encoder dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_op        (i_op),
    .i_rd        (i_rd),
    .i_rs1       (i_rs1),
    .i_rs2       (i_rs2),
    .i_imm       (i_imm),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_instr     (o_instr),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_w[$];
  logic        exp_e[$];
  logic        acc;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_instr;
  logic        prev_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Format packers written as plain field arithmetic.
  function automatic int fr(int f7, int rs2, int rs1, int f3, int rd, int opc);
    return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
  endfunction
  function automatic int fi(int imm, int rs1, int f3, int rd, int opc);
    return ((imm & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
  endfunction
  function automatic int fs(int imm, int rs2, int rs1, int f3);
    return (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((imm & 'h1F) << 7) | 'h23;
  endfunction
  function automatic int fb(int imm, int rs2, int rs1, int f3);
    return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
         | (f3 << 12) | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | 'h63;
  endfunction
  function automatic int fj(int imm, int rd);
    return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21) | (((imm >> 11) & 1) << 20)
         | (((imm >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
  endfunction

  task automatic beat(input int w, input logic e);
    exp_w.push_back(e ? 32'h0 : 32'(w));
    exp_e.push_back(e);
  endtask

  // Reference: the beats one accepted op should produce, straight from the ISA rules.
  task automatic model(input logic [5:0] op, input int rd, input int rs1, input int rs2, input int imm);
    int kind, f3, f7, hi, lo;
    logic [31:0] u;
    bit in12;
    kind = 11; f3 = 0; f7 = 0;
    case (op)
      OP_ADD:  begin kind = 0; f3 = 0; end
      OP_SUB:  begin kind = 0; f3 = 0; f7 = 32; end
      OP_SLL:  begin kind = 0; f3 = 1; end
      OP_SLT:  begin kind = 0; f3 = 2; end
      OP_SLTU: begin kind = 0; f3 = 3; end
      OP_XOR:  begin kind = 0; f3 = 4; end
      OP_SRL:  begin kind = 0; f3 = 5; end
      OP_SRA:  begin kind = 0; f3 = 5; f7 = 32; end
      OP_OR:   begin kind = 0; f3 = 6; end
      OP_AND:  begin kind = 0; f3 = 7; end
      OP_ADDI: begin kind = 1; f3 = 0; end
      OP_SLTI: begin kind = 1; f3 = 2; end
      OP_SLTIU:begin kind = 1; f3 = 3; end
      OP_XORI: begin kind = 1; f3 = 4; end
      OP_ORI:  begin kind = 1; f3 = 6; end
      OP_ANDI: begin kind = 1; f3 = 7; end
      OP_SLLI: begin kind = 2; f3 = 1; end
      OP_SRLI: begin kind = 2; f3 = 5; end
      OP_SRAI: begin kind = 2; f3 = 5; f7 = 32; end
      OP_LB:   begin kind = 3; f3 = 0; end
      OP_LH:   begin kind = 3; f3 = 1; end
      OP_LW:   begin kind = 3; f3 = 2; end
      OP_LBU:  begin kind = 3; f3 = 4; end
      OP_LHU:  begin kind = 3; f3 = 5; end
      OP_SB:   begin kind = 4; f3 = 0; end
      OP_SH:   begin kind = 4; f3 = 1; end
      OP_SW:   begin kind = 4; f3 = 2; end
      OP_BEQ:  begin kind = 5; f3 = 0; end
      OP_BNE:  begin kind = 5; f3 = 1; end
      OP_BLT:  begin kind = 5; f3 = 4; end
      OP_BGE:  begin kind = 5; f3 = 5; end
      OP_BLTU: begin kind = 5; f3 = 6; end
      OP_BGEU: begin kind = 5; f3 = 7; end
      OP_JAL:  kind = 6;
      OP_JALR: kind = 7;
      OP_LUI:  kind = 8;
      OP_AUIPC:kind = 9;
      OP_LI:   kind = 10;
      default: kind = 11;
    endcase
    in12 = (imm >= -2048) && (imm <= 2047);
    case (kind)
      0:  beat(fr(f7, rs2, rs1, f3, rd, 'h33), 1'b0);
      1:  beat(fi(imm, rs1, f3, rd, 'h13), !in12);
      2:  beat(fr(f7, imm & 31, rs1, f3, rd, 'h13), !(imm >= 0 && imm <= 31));
      3:  beat(fi(imm, rs1, f3, rd, 'h03), !in12);
      4:  beat(fs(imm, rs2, rs1, f3), !in12);
      5:  beat(fb(imm, rs2, rs1, f3), !(imm >= -4096 && imm <= 4094 && (imm & 1) == 0));
      6:  beat(fj(imm, rd), !(imm >= -(1 << 20) && imm <= (1 << 20) - 2 && (imm & 1) == 0));
      7:  beat(fi(imm, rs1, 0, rd, 'h67), !in12);
      8:  beat((imm & 'hFFFFF000) | (rd << 7) | 'h37, (imm & 'hFFF) != 0);
      9:  beat((imm & 'hFFFFF000) | (rd << 7) | 'h17, (imm & 'hFFF) != 0);
      10: begin
        if (in12) begin
          beat(fi(imm, 0, 0, rd, 'h13), 1'b0);
        end else begin
          u  = 32'(imm) + 32'h800;
          hi = int'(u >> 12);
          lo = imm - (hi << 12);
          beat((hi << 12) | (rd << 7) | 'h37, 1'b0);
          if (lo != 0) beat(fi(lo, rd, 0, rd, 'h13), 1'b0);
        end
      end
      default: beat(0, 1'b1);
    endcase
  endtask

  // One clock: inputs were driven at the falling edge; check, predict, then advance.
  task automatic tick();
    logic rst_now;
    logic exp_rdy;
    #1;
    rst_now = i_rst;
    acc = 1'b0;
    if (rst_now) begin
      chk("in_ready_in_reset", {31'd0, o_in_ready}, 32'd0);
    end else begin
      exp_rdy = (exp_w.size() == 0) || (exp_w.size() == 1 && i_out_ready);
      chk("out_valid", {31'd0, o_out_valid}, {31'd0, exp_w.size() > 0});
      chk("in_ready", {31'd0, o_in_ready}, {31'd0, exp_rdy});
      if (prev_stall) begin
        chk("stall_instr", o_instr, prev_instr);
        chk("stall_err", {31'd0, o_err}, {31'd0, prev_err});
      end
      if (o_out_valid && i_out_ready) begin
        if (exp_w.size() > 0) begin
          chk("beat_instr", o_instr, exp_w.pop_front());
          chk("beat_err", {31'd0, o_err}, {31'd0, exp_e.pop_front()});
        end else begin
          chk("unexpected_beat", {31'd0, o_out_valid}, 32'd0);
        end
      end
      acc = i_in_valid && o_in_ready;
      if (acc) model(i_op, int'(i_rd), int'(i_rs1), int'(i_rs2), int'(i_imm));
    end
    prev_stall = !rst_now && o_out_valid && !i_out_ready;
    prev_instr = o_instr;
    prev_err   = o_err;
    @(negedge clk);
    if (rst_now) begin
      exp_w.delete();
      exp_e.delete();
      prev_stall = 1'b0;
    end
  endtask

  task automatic send(input logic [5:0] op, input int rd, input int rs1, input int rs2,
                      input int imm, input bit rand_ready);
    int budget;
    i_op = op; i_rd = 5'(rd); i_rs1 = 5'(rs1); i_rs2 = 5'(rs2); i_imm = 32'(imm);
    i_in_valid = 1'b1;
    budget = 0;
    do begin
      if (rand_ready) i_out_ready = ($urandom_range(0, 3) != 0);
      tick();
      budget++;
    end while (!acc && budget < 50);
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    i_in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    budget = 0;
    while (exp_w.size() > 0 && budget < 20) begin
      tick();
      budget++;
    end
    if (exp_w.size() > 0) chk("drain_timeout", 32'(exp_w.size()), 32'd0);
  endtask

  function automatic int rand_imm();
    case ($urandom_range(0, 6))
      0: return int'($urandom_range(0, 80)) - 40;
      1: return int'($urandom_range(0, 35)) - 2;
      2: case ($urandom_range(0, 3))
           0: return -2049;
           1: return -2048;
           2: return 2047;
           default: return 2048;
         endcase
      3: return int'($urandom_range(0, 10000)) - 5000;
      4: return int'($urandom_range(0, 2200000)) - 1100000;
      5: return int'($urandom() & 32'hFFFFF000);
      default: return int'($urandom());
    endcase
  endfunction

  initial begin
    i_rst = 1'b1; i_in_valid = 1'b0; i_out_ready = 1'b0;
    i_op = '0; i_rd = '0; i_rs1 = '0; i_rs2 = '0; i_imm = '0;
    @(negedge clk);
    tick();
    tick();
    i_rst = 1'b0;
    #1;
    chk("reset_out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("reset_instr", o_instr, 32'h0);
    chk("reset_err", {31'd0, o_err}, 32'd0);

    i_out_ready = 1'b1;
    send(OP_ADD, 1, 2, 3, 0, 1'b0);
    chk("add_word", o_instr, 32'h003100B3);
    chk("add_err", {31'd0, o_err}, 32'd0);

    send(OP_LI, 5, 0, 0, 32'h12345678, 1'b0);
    chk("li_beat1", o_instr, 32'h123452B7);
    chk("li_ready_beat1", {31'd0, o_in_ready}, 32'd0);
    tick();
    chk("li_beat2", o_instr, 32'h67828293);
    send(OP_LI, 1, 0, 0, 32'h00000800, 1'b0);
    chk("li_carry_beat1", o_instr, 32'h000010B7);
    tick();
    chk("li_carry_beat2", o_instr, 32'h80008093);

    send(OP_BEQ, 0, 1, 2, 8, 1'b0);
    chk("beq_word", o_instr, 32'h00208463);
    send(OP_ADDI, 1, 1, 0, 2048, 1'b0);
    chk("addi_range_word", o_instr, 32'h0);
    chk("addi_range_err", {31'd0, o_err}, 32'd1);
    send(OP_BNE, 0, 1, 2, 3, 1'b0);
    chk("bne_odd_err", {31'd0, o_err}, 32'd1);
    send(OP_SRAI, 4, 6, 0, 31, 1'b0);
    chk("srai_word", o_instr, 32'h41F35213);
    drain();

    i_out_ready = 1'b0;
    send(OP_SW, 0, 1, 2, 8, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_ready_low", {31'd0, o_in_ready}, 32'd0);
      chk("bp_instr_hold", o_instr, 32'h0020A423);
    end
    i_op = OP_ADDI; i_rd = 5'd3; i_rs1 = 5'd0; i_rs2 = 5'd0; i_imm = 32'd5;
    i_in_valid = 1'b1; i_out_ready = 1'b1;
    tick();
    chk("bp_same_cycle_accept", {31'd0, acc}, 32'd1);
    chk("bp_next_word", o_instr, 32'h00500193);
    i_in_valid = 1'b0;
    drain();

    send(OP_LI, 5, 0, 0, 32'h12345678, 1'b0);
    i_rst = 1'b1; i_out_ready = 1'b0;
    tick();
    i_rst = 1'b0;
    #1;
    chk("rst_li_out_valid", {31'd0, o_out_valid}, 32'd0);
    i_out_ready = 1'b1;
    tick();
    tick();
    send(OP_ADD, 1, 2, 3, 0, 1'b0);
    chk("post_rst_add", o_instr, 32'h003100B3);
    drain();

    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 4) == 0) begin
        i_in_valid = 1'b0;
        i_out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end else begin
        op = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(38, 63)) : 6'($urandom_range(0, 37));
        send(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), rand_imm(), 1'b1);
      end
    end
    drain();
    tick();
    chk("final_idle", {31'd0, o_out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
